// File: rtl/mouse_master_sm_pkg.sv
// PS/2 mouse master: command/response bytes and controller state encodings.
package mouse_master_sm_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_STREAM   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_SELFTEST = 8'hAA;
    localparam logic [7:0] RSP_ID       = 8'h00;

    typedef enum logic [3:0] {
        ST_SEND_RST = 4'd0,
        ST_WT_SENT1 = 4'd1,
        ST_WT_ACK1  = 4'd2,
        ST_WT_BAT   = 4'd3,
        ST_WT_ID    = 4'd4,
        ST_SEND_EN  = 4'd5,
        ST_WT_SENT2 = 4'd6,
        ST_WT_ACK2  = 4'd7,
        ST_PKT_B0   = 4'd8,
        ST_PKT_B1   = 4'd9,
        ST_PKT_B2   = 4'd10,
        ST_PUBLISH  = 4'd11
    } state_t;

    // Init states that are guarded by the progress timeout.
    function automatic logic is_init_wait(input state_t s);
        return s inside {ST_WT_SENT1, ST_WT_ACK1, ST_WT_BAT, ST_WT_ID,
                         ST_SEND_EN, ST_WT_SENT2, ST_WT_ACK2};
    endfunction

    // States in which the receiver is armed.
    function automatic logic is_rx_state(input state_t s);
        return s inside {ST_WT_ACK1, ST_WT_BAT, ST_WT_ID, ST_WT_ACK2,
                         ST_PKT_B0, ST_PKT_B1, ST_PKT_B2};
    endfunction

endpackage

// File: rtl/mouse_master_sm.sv
// PS/2 mouse master: runs the reset/enable handshake, then assembles 3-byte
// movement packets and publishes them with a one-cycle interrupt.
module mouse_master_sm
    import mouse_master_sm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [7:0]       status_sh, dx_sh, dy_sh;
    logic [7:0]       status_sh_nxt, dx_sh_nxt, dy_sh_nxt;
    logic [7:0]       status_nxt, dx_nxt, dy_nxt, byte_to_send_nxt;
    logic             send_byte_nxt, read_enable_nxt, send_int_nxt;
    logic             rx_ok_c, tmo_hit_c;

    assign rx_ok_c   = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    assign tmo_hit_c = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // State, timeout counter, shadows and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= ST_SEND_RST;
            tmo_cnt        <= '0;
            status_sh      <= '0;
            dx_sh          <= '0;
            dy_sh          <= '0;
            SEND_BYTE      <= 1'b0;
            BYTE_TO_SEND   <= '0;
            READ_ENABLE    <= 1'b0;
            MOUSE_STATUS   <= '0;
            MOUSE_DX       <= '0;
            MOUSE_DY       <= '0;
            SEND_INTERRUPT <= 1'b0;
        end else begin
            state          <= state_nxt;
            tmo_cnt        <= (state_nxt == state && is_init_wait(state))
                              ? tmo_cnt + CNT_W'(1) : '0;
            status_sh      <= status_sh_nxt;
            dx_sh          <= dx_sh_nxt;
            dy_sh          <= dy_sh_nxt;
            SEND_BYTE      <= send_byte_nxt;
            BYTE_TO_SEND   <= byte_to_send_nxt;
            READ_ENABLE    <= read_enable_nxt;
            MOUSE_STATUS   <= status_nxt;
            MOUSE_DX       <= dx_nxt;
            MOUSE_DY       <= dy_nxt;
            SEND_INTERRUPT <= send_int_nxt;
        end
    end

    // Next state and next output values; a received byte beats timeout expiry.
    always_comb begin
        state_nxt        = state;
        send_byte_nxt    = 1'b0;
        byte_to_send_nxt = BYTE_TO_SEND;
        send_int_nxt     = 1'b0;
        status_nxt       = MOUSE_STATUS;
        dx_nxt           = MOUSE_DX;
        dy_nxt           = MOUSE_DY;
        status_sh_nxt    = status_sh;
        dx_sh_nxt        = dx_sh;
        dy_sh_nxt        = dy_sh;

        case (state)
            ST_SEND_RST: begin
                state_nxt        = ST_WT_SENT1;
                send_byte_nxt    = 1'b1;
                byte_to_send_nxt = CMD_RESET;
            end
            ST_WT_SENT1: begin
                if (BYTE_SENT)      state_nxt = ST_WT_ACK1;
                else if (tmo_hit_c) state_nxt = ST_SEND_RST;
            end
            ST_WT_ACK1: begin
                if (BYTE_READY)
                    state_nxt = (rx_ok_c && BYTE_READ == RSP_ACK) ? ST_WT_BAT : ST_SEND_RST;
                else if (tmo_hit_c) state_nxt = ST_SEND_RST;
            end
            ST_WT_BAT: begin
                if (BYTE_READY)
                    state_nxt = (rx_ok_c && BYTE_READ == RSP_SELFTEST) ? ST_WT_ID : ST_SEND_RST;
                else if (tmo_hit_c) state_nxt = ST_SEND_RST;
            end
            ST_WT_ID: begin
                if (BYTE_READY)
                    state_nxt = (rx_ok_c && BYTE_READ == RSP_ID) ? ST_SEND_EN : ST_SEND_RST;
                else if (tmo_hit_c) state_nxt = ST_SEND_RST;
            end
            ST_SEND_EN: begin
                state_nxt        = ST_WT_SENT2;
                send_byte_nxt    = 1'b1;
                byte_to_send_nxt = CMD_STREAM;
            end
            ST_WT_SENT2: begin
                if (BYTE_SENT)      state_nxt = ST_WT_ACK2;
                else if (tmo_hit_c) state_nxt = ST_SEND_RST;
            end
            ST_WT_ACK2: begin
                if (BYTE_READY)
                    state_nxt = (rx_ok_c && BYTE_READ == RSP_ACK) ? ST_PKT_B0 : ST_SEND_RST;
                else if (tmo_hit_c) state_nxt = ST_SEND_RST;
            end
            // Bit 3 is always set in a status byte; anything else is dropped to resync.
            ST_PKT_B0: begin
                if (rx_ok_c && BYTE_READ[3]) begin
                    status_sh_nxt = BYTE_READ;
                    state_nxt     = ST_PKT_B1;
                end
            end
            ST_PKT_B1: begin
                if (BYTE_READY) begin
                    if (rx_ok_c) begin
                        dx_sh_nxt = BYTE_READ;
                        state_nxt = ST_PKT_B2;
                    end else begin
                        state_nxt = ST_PKT_B0;
                    end
                end
            end
            ST_PKT_B2: begin
                if (BYTE_READY) begin
                    if (rx_ok_c) begin
                        dy_sh_nxt = BYTE_READ;
                        state_nxt = ST_PUBLISH;
                    end else begin
                        state_nxt = ST_PKT_B0;
                    end
                end
            end
            ST_PUBLISH: begin
                status_nxt   = status_sh;
                dx_nxt       = dx_sh;
                dy_nxt       = dy_sh;
                send_int_nxt = 1'b1;
                state_nxt    = ST_PKT_B0;
            end
            default: state_nxt = ST_SEND_RST;
        endcase

        read_enable_nxt = is_rx_state(state_nxt);
    end

endmodule
